// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 32;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter: clears to zero on load, increments per shifted bit, flags WIDTH-1.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        inc,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        tc
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// LSB-first parallel-in serial-out transmitter with valid/ready load handshake.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             tc;
  logic             transfer;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  always_comb begin
`ifdef PISO_PARITY_EN
    load_ready = (state == ST_IDLE) || (state == ST_PARITY);
`else
    load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && tc);
`endif
  end

  assign transfer = load_valid & load_ready;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (transfer),
    .inc   ((state == ST_SHIFT) && !tc),
    .cnt   (bit_cnt),
    .tc    (tc)
  );

  // Shift register doubles as the output register: ser_out is its LSB, cleared when idle.
  assign ser_out = shreg[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
`ifdef PISO_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (transfer) begin
        state       <= ST_SHIFT;
        shreg       <= data_in;
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        busy        <= 1'b1;
`ifdef PISO_PARITY_EN
        par         <= ^data_in;
`endif
      end else begin
        case (state)
          ST_SHIFT: begin
            if (tc) begin
`ifdef PISO_PARITY_EN
              state <= ST_PARITY;
              shreg <= WIDTH'(par);
`else
              state     <= ST_IDLE;
              shreg     <= '0;
              ser_valid <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              shreg <= shreg >> 1;
            end
          end
`ifdef PISO_PARITY_EN
          ST_PARITY: begin
            state     <= ST_IDLE;
            shreg     <= '0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Keeps the counter value observable for debug; bit_cnt is only consumed through tc.
  logic unused_cnt;
  assign unused_cnt = ^bit_cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed cycle tables plus randomized traffic vs. a queue model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, load_valid, load_ready, ser_out, ser_valid, frame_start, busy;
  logic [W-1:0] data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .data_in     (data_in),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  typedef struct {
    logic         rst;
    logic         lv;
    logic [W-1:0] din;
    logic         chk_rdy;
    logic         rdy;
    logic         so;
    logic         sv;
    logic         fs;
    logic         bz;
  } vec_t;

  typedef struct {
    bit b;
    bit fs;
  } sym_t;

  vec_t tbl[$];
  sym_t pend[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic lv, input logic [W-1:0] din, input logic chk_rdy,
                     input logic rdy, input logic so, input logic sv, input logic fs, input logic bz);
    vec_t v;
    v.rst = rst; v.lv = lv; v.din = din; v.chk_rdy = chk_rdy;
    v.rdy = rdy; v.so = so; v.sv = sv; v.fs = fs; v.bz = bz;
    tbl.push_back(v);
  endtask

  logic m_rdy, cur_v, cur_b, cur_fs;

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; data_in = '0;
    @(posedge clk);

    // rst lv din chk_rdy rdy so sv fs bz ; outputs are those seen in the cycle
    add(0,1,4'hF,0, 0,0,0,0,0); add(0,1,4'hF,0, 0,0,0,0,0); add(0,1,4'hF,0, 0,0,0,0,0);
    add(1,0,4'h0,1, 1,0,0,0,0);
`ifndef PISO_PARITY_EN
    // single word 1011
    add(1,1,4'hB,1, 1,0,0,0,0);
    add(1,0,4'h0,1, 0,1,1,1,1); add(1,0,4'h0,1, 0,1,1,0,1);
    add(1,0,4'h0,1, 0,0,1,0,1); add(1,0,4'h0,1, 1,1,1,0,1);
    add(1,0,4'h0,1, 1,0,0,0,0);
    // back-to-back 1011 then 0100 with load_valid held
    add(1,1,4'hB,1, 1,0,0,0,0);
    add(1,1,4'h4,1, 0,1,1,1,1); add(1,1,4'h4,1, 0,1,1,0,1);
    add(1,1,4'h4,1, 0,0,1,0,1); add(1,1,4'h4,1, 1,1,1,0,1);
    add(1,0,4'h0,1, 0,0,1,1,1); add(1,0,4'h0,1, 0,0,1,0,1);
    add(1,0,4'h0,1, 0,1,1,0,1); add(1,0,4'h0,1, 1,0,1,0,1);
    add(1,0,4'h0,1, 1,0,0,0,0);
    // busy rejection: 1111 offered from bit1 of 0001, taken at bit3
    add(1,1,4'h1,1, 1,0,0,0,0);
    add(1,0,4'h0,1, 0,1,1,1,1); add(1,1,4'hF,1, 0,0,1,0,1);
    add(1,1,4'hF,1, 0,0,1,0,1); add(1,1,4'hF,1, 1,0,1,0,1);
    add(1,0,4'h0,1, 0,1,1,1,1); add(1,0,4'h0,1, 0,1,1,0,1);
    add(1,0,4'h0,1, 0,1,1,0,1); add(1,0,4'h0,1, 1,1,1,0,1);
    add(1,0,4'h0,1, 1,0,0,0,0);
    // reset asserted during bit2 of 1010
    add(1,1,4'hA,1, 1,0,0,0,0);
    add(1,0,4'h0,1, 0,0,1,1,1); add(1,0,4'h0,1, 0,1,1,0,1);
    add(0,0,4'h0,0, 0,0,1,0,1);
    add(1,0,4'h0,1, 1,0,0,0,0); add(1,0,4'h0,1, 1,0,0,0,0); add(1,0,4'h0,1, 1,0,0,0,0);
`else
    // parity: 0111 then 0011 back-to-back, 5-cycle word period
    add(1,1,4'h7,1, 1,0,0,0,0);
    add(1,1,4'h3,1, 0,1,1,1,1); add(1,1,4'h3,1, 0,1,1,0,1);
    add(1,1,4'h3,1, 0,1,1,0,1); add(1,1,4'h3,1, 0,0,1,0,1);
    add(1,1,4'h3,1, 1,1,1,0,1);
    add(1,0,4'h0,1, 0,1,1,1,1); add(1,0,4'h0,1, 0,1,1,0,1);
    add(1,0,4'h0,1, 0,0,1,0,1); add(1,0,4'h0,1, 0,0,1,0,1);
    add(1,0,4'h0,1, 1,0,1,0,1);
    add(1,0,4'h0,1, 1,0,0,0,0);
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst; load_valid = tbl[i].lv; data_in = tbl[i].din;
      #1;
      if (tbl[i].chk_rdy) chk($sformatf("row%0d load_ready", i), load_ready, tbl[i].rdy);
      chk($sformatf("row%0d ser_out", i), ser_out, tbl[i].so);
      chk($sformatf("row%0d ser_valid", i), ser_valid, tbl[i].sv);
      chk($sformatf("row%0d frame_start", i), frame_start, tbl[i].fs);
      chk($sformatf("row%0d busy", i), busy, tbl[i].bz);
    end

    // randomized traffic against a symbol-queue model
    @(negedge clk);
    rst_n = 1'b0; load_valid = 1'b0;
    cur_v = 1'b0; cur_b = 1'b0; cur_fs = 1'b0;
    pend.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(99) != 0);
      load_valid = ($urandom_range(9) < 7);
      data_in    = W'($urandom);
      #1;
      m_rdy = (pend.size() == 0);
      if (rst_n) chk($sformatf("rnd%0d load_ready", cyc), load_ready, m_rdy);
      chk($sformatf("rnd%0d ser_valid", cyc), ser_valid, cur_v);
      chk($sformatf("rnd%0d ser_out", cyc), ser_out, cur_v & cur_b);
      chk($sformatf("rnd%0d frame_start", cyc), frame_start, cur_v & cur_fs);
      chk($sformatf("rnd%0d busy", cyc), busy, cur_v);
      if (!rst_n) begin
        pend.delete();
        cur_v = 1'b0; cur_b = 1'b0; cur_fs = 1'b0;
      end else begin
        if (load_valid && m_rdy) begin
          for (int k = 0; k < W; k++) pend.push_back('{b: data_in[k], fs: (k == 0)});
          if (PAR) pend.push_back('{b: ^data_in, fs: 1'b0});
        end
        if (pend.size() != 0) begin
          sym_t s;
          s = pend.pop_front();
          cur_v = 1'b1; cur_b = s.b; cur_fs = s.fs;
        end else begin
          cur_v = 1'b0; cur_b = 1'b0; cur_fs = 1'b0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
